// File: rtl/router_pkt_tx_pkg.sv
// Shared types and header layout for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PLD  = 3'd2,
    PAR  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_DEST_LSB = 0;

  // Field order matches the bit positions above: len in [7:2], dest in [1:0].
  typedef struct packed {
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len;
    logic [HDR_DEST_MSB-HDR_DEST_LSB:0] dest;
  } hdr_t;

endpackage

// File: rtl/router_pkt_tx_if.sv
// Handshake/bus bundle between a packet source and the router transmitter.
interface router_pkt_tx_if;
  logic       buf_we;
  logic [5:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       inj_err;
  logic       rtr_busy;
  logic       rtr_err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_busy;
  logic       done;
  logic       pkt_err;
  logic       cmd_err;

  modport master (
    output buf_we, buf_addr, buf_wdata, start, dest, len, inj_err, rtr_busy, rtr_err,
    input  pkt_valid, data_out, tx_busy, done, pkt_err, cmd_err
  );

  modport slave (
    input  buf_we, buf_addr, buf_wdata, start, dest, len, inj_err, rtr_busy, rtr_err,
    output pkt_valid, data_out, tx_busy, done, pkt_err, cmd_err
  );
endinterface

// File: rtl/pkt_tx_buf.sv
// 64x8 payload buffer: one write port, registered read with write-first bypass.
module pkt_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Bypass lets a byte written on the same edge it is prefetched still go out.
  always_ff @(posedge clk) begin
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: header, buffered payload, parity byte, then router error check.
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.slave bus
);
  import router_pkg::*;

  state_t     state;
  logic [7:0] out_r;
  logic [7:0] parity;
  logic [7:0] rdata;
  logic [5:0] len_r;
  logic [5:0] idx;
  logic [7:0] cnt;
  logic       pkt_r;
  logic       inj_r;
  logic       err_seen;
  logic       done_r;
  logic       pkt_err_r;
  logic       cmd_err_r;

  logic       accept;
  logic       start_ok;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       err_nxt;
  hdr_t       hdr;

  always_comb begin
    hdr      = '0;
    hdr.len  = bus.len;
    hdr.dest = bus.dest;
  end

  assign accept   = !bus.rtr_busy;
  assign start_ok = (bus.dest != ADDR_INVALID) && (bus.len != 6'd0) &&
                    (int'(bus.len) <= MAX_LEN);
  assign err_nxt  = err_seen | bus.rtr_err;

  // Prefetch: the byte after the one on data_out is read on each accepted edge.
  assign rd_en   = accept && ((state == HDR) || (state == PLD));
  assign rd_addr = (state == HDR) ? 6'd0 : idx + 6'd1;

  pkt_tx_buf u_buf (
    .clk   (clk),
    .we    (bus.buf_we),
    .waddr (bus.buf_addr),
    .wdata (bus.buf_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      out_r     <= 8'd0;
      parity    <= 8'd0;
      len_r     <= 6'd0;
      idx       <= 6'd0;
      cnt       <= 8'd0;
      pkt_r     <= 1'b0;
      inj_r     <= 1'b0;
      err_seen  <= 1'b0;
      done_r    <= 1'b0;
      pkt_err_r <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      pkt_err_r <= 1'b0;
      cmd_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (start_ok) begin
              state  <= HDR;
              len_r  <= bus.len;
              inj_r  <= bus.inj_err;
              out_r  <= hdr;
              parity <= hdr;
              pkt_r  <= 1'b1;
            end else begin
              cmd_err_r <= 1'b1;
            end
          end
        end
        HDR: begin
          if (accept) begin
            state <= PLD;
            idx   <= 6'd0;
          end
        end
        PLD: begin
          if (accept) begin
            parity <= parity ^ rdata;
            if (idx == len_r - 6'd1) begin
              state <= PAR;
              pkt_r <= 1'b0;
              out_r <= parity ^ rdata ^ {7'b0, inj_r};
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        PAR: begin
          if (accept) begin
            state    <= CHK;
            out_r    <= 8'd0;
            cnt      <= 8'd0;
            err_seen <= 1'b0;
          end
        end
        CHK: begin
          err_seen <= err_nxt;
          if (cnt == 8'(ERR_WAIT - 1)) begin
            state     <= IDLE;
            done_r    <= 1'b1;
            pkt_err_r <= err_nxt;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload bytes come straight from the buffer's read register.
  assign bus.data_out  = (state == PLD) ? rdata : out_r;
  assign bus.pkt_valid = pkt_r;
  assign bus.tx_busy   = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.pkt_err   = pkt_err_r;
  assign bus.cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with hand-computed byte sequences.
module tb_router_pkt_tx;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-cycle capture: flags = {pkt_valid, done, tx_busy, cmd_err}
  logic [7:0] od  [100];
  logic [3:0] of  [100];
  logic       ope [100];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.buf_we    = 1'b1;
    bus.buf_addr  = a;
    bus.buf_wdata = d;
    tick();
    bus.buf_we = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] d, input logic [5:0] l, input logic inj);
    bus.start   = 1'b1;
    bus.dest    = d;
    bus.len     = l;
    bus.inj_err = inj;
    tick();
    bus.start   = 1'b0;
    bus.inj_err = 1'b0;
  endtask

  // Records outputs for n cycles; bs/bl stall window, ea rtr_err cycle, sa extra start, wa buffer write.
  task automatic capture(input int n, input int bs, input int bl, input int ea, input int sa,
                         input int wa, input logic [5:0] wad, input logic [7:0] wd);
    for (int i = 0; i < n; i++) begin
      bus.rtr_busy = (i >= bs) && (i < bs + bl);
      bus.rtr_err  = (i == ea);
      bus.start    = (i == sa);
      if (i == sa) begin
        bus.dest = 2'd1;
        bus.len  = 6'd5;
      end
      bus.buf_we    = (i == wa);
      bus.buf_addr  = wad;
      bus.buf_wdata = wd;
      od[i]  = bus.data_out;
      of[i]  = {bus.pkt_valid, bus.done, bus.tx_busy, bus.cmd_err};
      ope[i] = bus.pkt_err;
      tick();
    end
    bus.rtr_busy = 1'b0;
    bus.rtr_err  = 1'b0;
    bus.start    = 1'b0;
    bus.buf_we   = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({bus.data_out, bus.pkt_valid, bus.tx_busy, bus.done, bus.pkt_err, bus.cmd_err} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got data=%h v=%b busy=%b done=%b perr=%b cerr=%b, want all 0",
               bus.data_out, bus.pkt_valid, bus.tx_busy, bus.done, bus.pkt_err, bus.cmd_err);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.data_out, bus.pkt_valid, bus.tx_busy} !== 10'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got data=%h v=%b busy=%b, want 0", bus.data_out, bus.pkt_valid, bus.tx_busy);
    end
  endtask

  task automatic test_reject();
    logic [1:0] dd [2] = '{2'd3, 2'd1};
    logic [5:0] ll [2] = '{6'd3, 6'd0};
    for (int k = 0; k < 2; k++) begin
      do_start(dd[k], ll[k], 1'b0);
      n_cmp++;
      if ({bus.cmd_err, bus.tx_busy, bus.pkt_valid, bus.data_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
        n_err++;
        $display("FAIL reject%0d_pulse: got cerr=%b busy=%b v=%b data=%h, want 1 0 0 00",
                 k, bus.cmd_err, bus.tx_busy, bus.pkt_valid, bus.data_out);
      end
      tick();
      n_cmp++;
      if ({bus.cmd_err, bus.tx_busy, bus.pkt_valid} !== 3'b000) begin
        n_err++;
        $display("FAIL reject%0d_after: got cerr=%b busy=%b v=%b, want 0 0 0",
                 k, bus.cmd_err, bus.tx_busy, bus.pkt_valid);
      end
    end
  endtask

  task automatic test_nominal();
    logic [7:0] eq [$] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic [7:0] ed;
    logic [3:0] ef;
    int nb, nd;
    nb = eq.size();
    nd = nb + EW;
    do_start(2'd1, 6'd3, 1'b0);
    capture(nd + 1, -1, 0, -1, -1, -1, 6'd0, 8'd0);
    for (int i = 0; i <= nd; i++) begin
      ed = (i < nb) ? eq[i] : 8'h00;
      ef = {(i < nb - 1), (i == nd), (i < nd), 1'b0};
      n_cmp++;
      if ({od[i], of[i]} !== {ed, ef}) begin
        n_err++;
        $display("FAIL nominal cyc%0d: got data=%h flags=%b, want data=%h flags=%b", i, od[i], of[i], ed, ef);
      end
    end
    n_cmp++;
    if (ope[nd] !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_pkt_err: got %b, want 0", ope[nd]);
    end
  endtask

  task automatic test_stall();
    logic [7:0] eq [$] = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D};
    logic [7:0] ed;
    logic [3:0] ef;
    int nb, nd;
    nb = eq.size();
    nd = nb + EW;
    do_start(2'd1, 6'd3, 1'b0);
    capture(nd + 1, 2, 2, -1, -1, -1, 6'd0, 8'd0);
    for (int i = 0; i <= nd; i++) begin
      ed = (i < nb) ? eq[i] : 8'h00;
      ef = {(i < nb - 1), (i == nd), (i < nd), 1'b0};
      n_cmp++;
      if ({od[i], of[i]} !== {ed, ef}) begin
        n_err++;
        $display("FAIL stall cyc%0d: got data=%h flags=%b, want data=%h flags=%b", i, od[i], of[i], ed, ef);
      end
    end
  endtask

  task automatic test_inj_err();
    // header {2,2}=0x0A; parity 0x0A^0x11^0x22=0x39, bit0 flipped -> 0x38
    logic [7:0] eq [$] = '{8'h0A, 8'h11, 8'h22, 8'h38};
    logic [7:0] ed;
    logic [3:0] ef;
    int nb, nd;
    nb = eq.size();
    nd = nb + EW;
    do_start(2'd2, 6'd2, 1'b1);
    capture(nd + 1, -1, 0, nb + 1, -1, -1, 6'd0, 8'd0);
    for (int i = 0; i <= nd; i++) begin
      ed = (i < nb) ? eq[i] : 8'h00;
      ef = {(i < nb - 1), (i == nd), (i < nd), 1'b0};
      n_cmp++;
      if ({od[i], of[i]} !== {ed, ef}) begin
        n_err++;
        $display("FAIL inj_err cyc%0d: got data=%h flags=%b, want data=%h flags=%b", i, od[i], of[i], ed, ef);
      end
    end
    n_cmp++;
    if (ope[nd] !== 1'b1) begin
      n_err++;
      $display("FAIL inj_err_pkt_err: got %b, want 1", ope[nd]);
    end
  endtask

  task automatic test_wr_during_pld();
    // buf[2] rewritten to 0x5A on the edge it is prefetched; parity 0x0D^0x11^0x22^0x5A=0x64
    logic [7:0] eq [$] = '{8'h0D, 8'h11, 8'h22, 8'h5A, 8'h64};
    logic [7:0] ed;
    logic [3:0] ef;
    int nb, nd;
    nb = eq.size();
    nd = nb + EW;
    do_start(2'd1, 6'd3, 1'b0);
    capture(nd + 1, -1, 0, -1, -1, 2, 6'd2, 8'h5A);
    for (int i = 0; i <= nd; i++) begin
      ed = (i < nb) ? eq[i] : 8'h00;
      ef = {(i < nb - 1), (i == nd), (i < nd), 1'b0};
      n_cmp++;
      if ({od[i], of[i]} !== {ed, ef}) begin
        n_err++;
        $display("FAIL wr_pld cyc%0d: got data=%h flags=%b, want data=%h flags=%b", i, od[i], of[i], ed, ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_start(2'd1, 6'd3, 1'b0);
    tick();
    n_cmp++;
    if ({bus.data_out, bus.pkt_valid} !== {8'h11, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid_pre: got data=%h v=%b, want 11 1", bus.data_out, bus.pkt_valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.data_out, bus.pkt_valid, bus.tx_busy, bus.done, bus.pkt_err, bus.cmd_err} !== 13'd0) begin
      n_err++;
      $display("FAIL rst_mid_zero: got data=%h v=%b busy=%b done=%b perr=%b cerr=%b, want all 0",
               bus.data_out, bus.pkt_valid, bus.tx_busy, bus.done, bus.pkt_err, bus.cmd_err);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({bus.done, bus.tx_busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_mid_nodone cyc%0d: got done=%b busy=%b, want 0 0", i, bus.done, bus.tx_busy);
      end
    end
    wr(6'd0, 8'h11);
    wr(6'd1, 8'h22);
    wr(6'd2, 8'h33);
    test_nominal();
  endtask

  task automatic test_back_to_back();
    logic [7:0] eq [$];
    logic [7:0] bb [64];
    logic [7:0] p;
    logic [7:0] ed;
    logic [3:0] ef;
    int nb, nd, n;
    for (int k = 0; k < 64; k++) begin
      bb[k] = 8'((k * 7 + 3) & 255);
      wr(6'(k), bb[k]);
    end
    p = 8'hFC;
    eq.push_back(8'hFC);
    for (int k = 0; k < 63; k++) begin
      eq.push_back(bb[k]);
      p = p ^ bb[k];
    end
    eq.push_back(p);
    nb = eq.size();
    nd = nb + EW;
    n  = nd + 4;
    do_start(2'd0, 6'd63, 1'b0);
    capture(n, -1, 0, -1, 10, -1, 6'd0, 8'd0);
    n_cmp++;
    if (nb !== 65) begin
      n_err++;
      $display("FAIL b2b_count: got %0d bytes, want 65", nb);
    end
    for (int i = 0; i < n; i++) begin
      ed = (i < nb) ? eq[i] : 8'h00;
      ef = {(i < nb - 1), (i == nd), (i < nd), 1'b0};
      n_cmp++;
      if ({od[i], of[i]} !== {ed, ef}) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got data=%h flags=%b, want data=%h flags=%b", i, od[i], of[i], ed, ef);
      end
    end
  endtask

  initial begin
    bus.buf_we    = 1'b0;
    bus.buf_addr  = 6'd0;
    bus.buf_wdata = 8'd0;
    bus.start     = 1'b0;
    bus.dest      = 2'd0;
    bus.len       = 6'd0;
    bus.inj_err   = 1'b0;
    bus.rtr_busy  = 1'b0;
    bus.rtr_err   = 1'b0;
    test_reset();
    test_reject();
    wr(6'd0, 8'h11);
    wr(6'd1, 8'h22);
    wr(6'd2, 8'h33);
    test_nominal();
    test_stall();
    test_inj_err();
    test_wr_during_pld();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
